// File: rtl/bp_pkg.sv
// Shared types and helpers for the gshare branch predictor: FSM state,
// counter reset value and PHT index hash.
package bp_pkg;

    typedef enum logic [0:0] {
        BP_INIT  = 1'b0,
        BP_READY = 1'b1
    } bp_state_t;

    localparam int unsigned CTR_MAX_BITS = 4;

    // Weakly-not-taken value for a counter of the given width.
    function automatic logic [CTR_MAX_BITS-1:0] ctr_init(input int unsigned ctr_bits);
        return CTR_MAX_BITS'((32'd1 << (ctr_bits - 32'd1)) - 32'd1);
    endfunction

    // Word-aligned PC optionally folded with the global history, masked to pidx bits.
    function automatic logic [31:0] pht_hash(input logic [31:0]   pc,
                                             input logic [31:0]   ghr,
                                             input int unsigned   pidx,
                                             input logic          hash_en);
        logic [31:0] mask;
        mask = (32'd1 << pidx) - 32'd1;
        return ((pc >> 2) ^ (hash_en ? ghr : 32'd0)) & mask;
    endfunction

endpackage

// File: rtl/gshare_predictor_if.sv
// Fetch/execute-facing bundle of the gshare predictor; master is the
// pipeline side, slave is the predictor.
interface gshare_predictor_if #(
    parameter int unsigned GHR_BITS = 8
);
    logic                ready;
    logic                predict_valid;
    logic [31:0]         pc_in;
    logic                pred_valid;
    logic                pred_hit;
    logic                pred_taken;
    logic [31:0]         pred_target;
    logic [GHR_BITS-1:0] pred_ghr;
    logic                update_valid;
    logic [31:0]         update_pc;
    logic                update_taken;
    logic [31:0]         update_target;
    logic [GHR_BITS-1:0] update_ghr;
    logic                update_mispredict;

    modport master (
        input  ready, pred_valid, pred_hit, pred_taken, pred_target, pred_ghr,
        output predict_valid, pc_in,
        output update_valid, update_pc, update_taken, update_target, update_ghr,
               update_mispredict
    );

    modport slave (
        output ready, pred_valid, pred_hit, pred_taken, pred_target, pred_ghr,
        input  predict_valid, pc_in,
        input  update_valid, update_pc, update_taken, update_target, update_ghr,
               update_mispredict
    );
endinterface

// File: rtl/bp_sat_counter.sv
// Combinational next value of an up/down saturating counter.
module bp_sat_counter #(
    parameter int unsigned CTR_BITS = 2
) (
    input  logic [CTR_BITS-1:0] ctr_i,
    input  logic                taken_i,
    output logic [CTR_BITS-1:0] next_ctr_c_o
);
    localparam logic [CTR_BITS-1:0] CTR_MAX = '1;

    always_comb begin
        next_ctr_c_o = ctr_i;
        if (taken_i) begin
            if (ctr_i != CTR_MAX) next_ctr_c_o = ctr_i + CTR_BITS'(1);
        end else begin
            if (ctr_i != '0) next_ctr_c_o = ctr_i - CTR_BITS'(1);
        end
    end
endmodule

// File: rtl/gshare_predictor.sv
// Gshare/bimodal direction predictor with tagged BTB and repairable global history.
// Define GSHARE_HASH_EN to fold the GHR into the PHT index; otherwise bimodal.
module gshare_predictor
    import bp_pkg::*;
#(
    parameter int unsigned PHT_ENTRIES = 1024,
    parameter int unsigned BTB_ENTRIES = 256,
    parameter int unsigned GHR_BITS    = 8,
    parameter int unsigned CTR_BITS    = 2,
    parameter int unsigned TAG_BITS    = 16
) (
    input logic               clk,
    input logic               rst,
    gshare_predictor_if.slave bp
);
    localparam int unsigned PIDX = $clog2(PHT_ENTRIES);
    localparam int unsigned BIDX = $clog2(BTB_ENTRIES);
    localparam int unsigned MAXE = (PHT_ENTRIES > BTB_ENTRIES) ? PHT_ENTRIES : BTB_ENTRIES;
    localparam int unsigned IDXW = $clog2(MAXE) + 1;
    localparam logic [CTR_BITS-1:0] WNT = CTR_BITS'(ctr_init(CTR_BITS));

`ifdef GSHARE_HASH_EN
    localparam logic HASH_EN = 1'b1;
`else
    localparam logic HASH_EN = 1'b0;
`endif

    bp_state_t state_q, state_d;
    logic [IDXW-1:0]     idx_q, idx_d;
    logic                ready_q, ready_d;
    logic                init_pht_we, init_btb_we;
    logic [GHR_BITS-1:0] ghr_q, ghr_d;

    logic                pred_valid_q, pred_hit_q, pred_taken_q;
    logic [31:0]         pred_target_q;
    logic [GHR_BITS-1:0] pred_ghr_q;

    // Tables carry no reset; the init sweep establishes their contents.
    logic [CTR_BITS-1:0] pht_q     [PHT_ENTRIES];
    logic                btb_vld_q [BTB_ENTRIES];
    logic [TAG_BITS-1:0] btb_tag_q [BTB_ENTRIES];
    logic [31:0]         btb_tgt_q [BTB_ENTRIES];

    logic                lookup, update;
    logic [PIDX-1:0]     lk_pidx, up_pidx;
    logic [BIDX-1:0]     lk_bidx, up_bidx;
    logic [TAG_BITS-1:0] lk_tag, up_tag;
    logic                lk_hit, lk_taken;
    logic [CTR_BITS-1:0] up_ctr, up_ctr_nxt;

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= BP_INIT;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // FSM: next state; the sweep advances one entry per cycle
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            BP_INIT: begin
                if (idx_q == IDXW'(MAXE)) state_d = BP_READY;
                else                      idx_d   = idx_q + IDXW'(1);
            end
            BP_READY: ;
            default:  state_d = BP_INIT;
        endcase
    end

    // FSM: outputs
    always_comb begin
        ready_d     = (state_d == BP_READY);
        init_pht_we = (state_q == BP_INIT) && (idx_q < IDXW'(PHT_ENTRIES)) && !rst;
        init_btb_we = (state_q == BP_INIT) && (idx_q < IDXW'(BTB_ENTRIES)) && !rst;
    end

    assign lookup = (state_q == BP_READY) && bp.predict_valid && !rst;
    assign update = (state_q == BP_READY) && bp.update_valid && !rst;

    assign lk_pidx  = PIDX'(pht_hash(bp.pc_in, 32'(ghr_q), PIDX, HASH_EN));
    assign lk_bidx  = BIDX'(bp.pc_in >> 2);
    assign lk_tag   = TAG_BITS'(bp.pc_in >> (BIDX + 2));
    assign lk_hit   = btb_vld_q[lk_bidx] && (btb_tag_q[lk_bidx] == lk_tag);
    assign lk_taken = lk_hit && pht_q[lk_pidx][CTR_BITS-1];

    assign up_pidx = PIDX'(pht_hash(bp.update_pc, 32'(bp.update_ghr), PIDX, HASH_EN));
    assign up_bidx = BIDX'(bp.update_pc >> 2);
    assign up_tag  = TAG_BITS'(bp.update_pc >> (BIDX + 2));
    assign up_ctr  = pht_q[up_pidx];

    bp_sat_counter #(.CTR_BITS(CTR_BITS)) u_ctr (
        .ctr_i        (up_ctr),
        .taken_i      (bp.update_taken),
        .next_ctr_c_o (up_ctr_nxt)
    );

    // Mispredict repair takes priority over a same-cycle speculative shift.
    always_comb begin
        ghr_d = ghr_q;
        if (update && bp.update_mispredict)
            ghr_d = GHR_BITS'({bp.update_ghr, bp.update_taken});
        else if (lookup && lk_hit)
            ghr_d = GHR_BITS'({ghr_q, lk_taken});
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ready_q       <= 1'b0;
            ghr_q         <= '0;
            pred_valid_q  <= 1'b0;
            pred_hit_q    <= 1'b0;
            pred_taken_q  <= 1'b0;
            pred_target_q <= '0;
            pred_ghr_q    <= '0;
        end else begin
            ready_q       <= ready_d;
            ghr_q         <= ghr_d;
            pred_valid_q  <= lookup;
            pred_hit_q    <= lookup && lk_hit;
            pred_taken_q  <= lookup && lk_taken;
            pred_target_q <= (lookup && lk_hit) ? btb_tgt_q[lk_bidx] : 32'd0;
            pred_ghr_q    <= lookup ? ghr_q : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (init_pht_we)  pht_q[PIDX'(idx_q)] <= WNT;
        else if (update)  pht_q[up_pidx]      <= up_ctr_nxt;
    end

    always_ff @(posedge clk) begin
        if (init_btb_we) begin
            btb_vld_q[BIDX'(idx_q)] <= 1'b0;
        end else if (update && bp.update_taken) begin
            btb_vld_q[up_bidx] <= 1'b1;
            btb_tag_q[up_bidx] <= up_tag;
            btb_tgt_q[up_bidx] <= bp.update_target;
        end
    end

    assign bp.ready       = ready_q;
    assign bp.pred_valid  = pred_valid_q;
    assign bp.pred_hit    = pred_hit_q;
    assign bp.pred_taken  = pred_taken_q;
    assign bp.pred_target = pred_target_q;
    assign bp.pred_ghr    = pred_ghr_q;

endmodule

// File: tb/tb_gshare_predictor.sv
// Scoreboard bench for gshare_predictor: a behavioural table model predicts each
// lookup when it is driven; results are compared as pred_valid pulses arrive.
module tb_gshare_predictor;

    localparam int unsigned PHT = 1024;
    localparam int unsigned BTB = 256;
    localparam int unsigned GB  = 8;
`ifdef GSHARE_HASH_EN
    localparam bit HASH = 1'b1;
`else
    localparam bit HASH = 1'b0;
`endif

    typedef struct packed {
        logic        hit;
        logic        taken;
        logic [31:0] target;
        logic [7:0]  ghr;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    gshare_predictor_if #(.GHR_BITS(GB)) bp_if ();

    gshare_predictor #(
        .PHT_ENTRIES (PHT),
        .BTB_ENTRIES (BTB),
        .GHR_BITS    (GB),
        .CTR_BITS    (2),
        .TAG_BITS    (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bp  (bp_if)
    );

    exp_t        sb_q[$];
    exp_t        mon_e;
    int unsigned n_chk = 0;
    int unsigned n_err = 0;
    int unsigned pv_cnt = 0;

    int unsigned m_pht [PHT];
    bit          m_bv  [BTB];
    logic [15:0] m_tag [BTB];
    logic [31:0] m_tgt [BTB];
    logic [7:0]  m_ghr;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int unsigned m_pidx(input logic [31:0] pc, input logic [7:0] ghr);
        return ((pc / 4) ^ (HASH ? 32'(ghr) : 32'd0)) % PHT;
    endfunction

    function automatic int unsigned m_bidx(input logic [31:0] pc);
        return (pc / 4) % BTB;
    endfunction

    function automatic logic [15:0] m_tagof(input logic [31:0] pc);
        return 16'(pc / (4 * BTB));
    endfunction

    task automatic model_reset();
        for (int i = 0; i < PHT; i++) m_pht[i] = 1;
        for (int i = 0; i < BTB; i++) m_bv[i] = 1'b0;
        m_ghr = '0;
    endtask

    task automatic idle_inputs();
        bp_if.predict_valid     = 1'b0;
        bp_if.pc_in             = '0;
        bp_if.update_valid      = 1'b0;
        bp_if.update_pc         = '0;
        bp_if.update_taken      = 1'b0;
        bp_if.update_target     = '0;
        bp_if.update_ghr        = '0;
        bp_if.update_mispredict = 1'b0;
    endtask

    // One cycle of stimulus; the lookup is modelled against pre-update contents.
    task automatic drive(input bit pv, input logic [31:0] pc,
                         input bit uv, input logic [31:0] upc, input bit ut,
                         input logic [31:0] utgt, input logic [7:0] ughr, input bit umis);
        exp_t        e;
        logic [7:0]  g_nxt;
        int unsigned pi, bi;
        bp_if.predict_valid     = pv;
        bp_if.pc_in             = pc;
        bp_if.update_valid      = uv;
        bp_if.update_pc         = upc;
        bp_if.update_taken      = ut;
        bp_if.update_target     = utgt;
        bp_if.update_ghr        = ughr;
        bp_if.update_mispredict = umis;
        g_nxt = m_ghr;
        if (pv) begin
            pi       = m_pidx(pc, m_ghr);
            bi       = m_bidx(pc);
            e.hit    = m_bv[bi] && (m_tag[bi] == m_tagof(pc));
            e.taken  = e.hit && (m_pht[pi] >= 2);
            e.target = e.hit ? m_tgt[bi] : 32'd0;
            e.ghr    = m_ghr;
            sb_q.push_back(e);
            if (e.hit) g_nxt = {m_ghr[6:0], e.taken};
        end
        if (uv) begin
            pi = m_pidx(upc, ughr);
            if (ut && m_pht[pi] < 3)       m_pht[pi]++;
            else if (!ut && m_pht[pi] > 0) m_pht[pi]--;
            if (ut) begin
                bi        = m_bidx(upc);
                m_bv[bi]  = 1'b1;
                m_tag[bi] = m_tagof(upc);
                m_tgt[bi] = utgt;
            end
            if (umis) g_nxt = {ughr[6:0], ut};
        end
        m_ghr = g_nxt;
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    task automatic lookup(input logic [31:0] pc);
        drive(1'b1, pc, 1'b0, 32'd0, 1'b0, 32'd0, 8'd0, 1'b0);
    endtask

    task automatic upd(input logic [31:0] pc, input bit t, input logic [31:0] tgt,
                       input logic [7:0] ghr, input bit mis);
        drive(1'b0, 32'd0, 1'b1, pc, t, tgt, ghr, mis);
    endtask

    task automatic wait_ready(output int unsigned n);
        n = 0;
        while (n < 3000) begin
            @(posedge clk);
            #1;
            n++;
            if (bp_if.ready === 1'b1) break;
        end
    endtask

    // Pops one expectation per result strobe.
    always @(negedge clk) begin
        if (bp_if.pred_valid === 1'b1) begin
            pv_cnt++;
            if (sb_q.size() == 0) begin
                check_eq("pred_spurious", 32'd1, 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                check_eq("pred_hit",    32'(bp_if.pred_hit),   32'(mon_e.hit));
                check_eq("pred_taken",  32'(bp_if.pred_taken), 32'(mon_e.taken));
                check_eq("pred_target", bp_if.pred_target,     mon_e.target);
                check_eq("pred_ghr",    32'(bp_if.pred_ghr),   32'(mon_e.ghr));
            end
        end
    end

    logic [31:0] pcs [6];
    int unsigned n_rdy;

    initial begin
        pcs = '{32'h100, 32'h300, 32'h600, 32'h700, 32'h900, 32'h500};
        rst = 1'b1;
        idle_inputs();
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_ready",       32'(bp_if.ready),      32'd0);
        check_eq("rst_pred_valid",  32'(bp_if.pred_valid), 32'd0);
        check_eq("rst_pred_hit",    32'(bp_if.pred_hit),   32'd0);
        check_eq("rst_pred_taken",  32'(bp_if.pred_taken), 32'd0);
        check_eq("rst_pred_target", bp_if.pred_target,     32'd0);
        check_eq("rst_pred_ghr",    32'(bp_if.pred_ghr),   32'd0);

        // Sweep with live-looking traffic that must be ignored, reset midway.
        rst = 1'b0;
        bp_if.predict_valid = 1'b1;
        bp_if.pc_in         = 32'h100;
        bp_if.update_valid  = 1'b1;
        bp_if.update_pc     = 32'h100;
        bp_if.update_taken  = 1'b1;
        bp_if.update_target = 32'hDEAD;
        repeat (500) @(posedge clk);
        #1;
        check_eq("ready_mid_sweep", 32'(bp_if.ready), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        wait_ready(n_rdy);
        idle_inputs();
        check_eq("ready_latency", n_rdy, 32'd1025);
        check_eq("init_no_pred", pv_cnt, 32'd0);
        model_reset();

        // Defaults after sweep
        lookup(32'h100);
        lookup(32'h2468);

        // Training
        upd(32'h100, 1'b1, 32'h200, 8'h00, 1'b0);
        upd(32'h100, 1'b1, 32'h200, 8'h00, 1'b0);
        lookup(32'h100);
        lookup(32'h104);

        // Saturation
        repeat (5) upd(32'h300, 1'b1, 32'h340, 8'h00, 1'b0);
        upd(32'h300, 1'b0, 32'h0, 8'h00, 1'b0);
        lookup(32'h300);
        repeat (3) upd(32'h300, 1'b0, 32'h0, 8'h00, 1'b0);
        lookup(32'h300);

        // Mispredict repair
        upd(32'hF00, 1'b0, 32'h0, 8'h00, 1'b1);
        repeat (3) lookup(32'h100);
        upd(32'h500, 1'b0, 32'h0, 8'h01, 1'b1);
        lookup(32'h100);

        // Same-cycle repair vs lookup, and same-entry update vs lookup
        drive(1'b1, 32'h100, 1'b1, 32'h500, 1'b0, 32'h0, 8'h10, 1'b1);
        lookup(32'h100);
        drive(1'b1, 32'h600, 1'b1, 32'h600, 1'b1, 32'h660, 8'h00, 1'b0);
        lookup(32'h600);

        // Tag alias
        lookup(32'h100 + 4 * BTB);

        // History independence of training in bimodal mode
        upd(32'h700, 1'b1, 32'h770, 8'h55, 1'b0);
        upd(32'h700, 1'b1, 32'h770, 8'hAA, 1'b0);
        lookup(32'h700);

        // Mixed random traffic
        for (int i = 0; i < 300; i++) begin
            drive(1'($urandom_range(0, 1)), pcs[$urandom_range(0, 5)],
                  1'($urandom_range(0, 1)), pcs[$urandom_range(0, 5)],
                  1'($urandom_range(0, 1)), 32'($urandom_range(0, 255)) << 2,
                  8'($urandom_range(0, 255)), 1'($urandom_range(0, 3) == 0));
        end

        repeat (3) @(posedge clk);
        #1;
        check_eq("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
